// File: rtl/vector_wb_assembler.sv
// vector_wb_assembler: packs lane results into one 128-bit vector and issues a single-cycle register-file write.
module vector_wb_assembler #(
  parameter int LANES  = 16,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  input  logic [ADDR_W-1:0]         cmd_dest,
  output logic                      cmd_ready,
  input  logic                      lane_valid,
  input  logic [LANE_W-1:0]         lane_data,
  output logic                      lane_ready,
  input  logic                      flush,
  output logic                      wre,
  output logic [ADDR_W-1:0]         a3,
  output logic [LANES*LANE_W-1:0]   wd3,
  output logic                      busy,
  output logic [$clog2(LANES):0]    lane_cnt
);
  localparam int CW = $clog2(LANES) + 1;
  localparam int DW = LANES * LANE_W;
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, WRITE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] dest_q, dest_d, a3_q, a3_d;
  logic [DW-1:0]     buf_q, buf_d, wd3_q, wd3_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              accept;

  assign accept = (state_q == COLLECT) && lane_valid;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    a3_d    = a3_q;
    wd3_d   = wd3_q;
    if (state_q == IDLE && cmd_valid) begin
      state_d = COLLECT;
      dest_d  = cmd_dest;
      buf_d   = '0;
      cnt_d   = '0;
    end
    for (int i = 0; i < LANES; i++)
      if (accept && cnt_q == CW'(i)) buf_d[i*LANE_W +: LANE_W] = lane_data;
    if (accept) cnt_d = cnt_q + 1'b1;
    // Output registers capture the vector as it enters WRITE so a3/wd3 hold until the next write.
    if (state_q == COLLECT && (flush || (accept && cnt_q == CW'(LANES-1)))) begin
      state_d = WRITE;
      a3_d    = dest_q;
      wd3_d   = buf_d;
    end
    if (state_q == WRITE) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dest_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      a3_q    <= '0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      a3_q    <= a3_d;
      wd3_q   <= wd3_d;
    end
  end

  assign cmd_ready  = state_q == IDLE;
  assign lane_ready = state_q == COLLECT;
  assign busy       = state_q != IDLE;
  assign wre        = state_q == WRITE;
  assign a3         = a3_q;
  assign wd3        = wd3_q;
  assign lane_cnt   = cnt_q;
endmodule

// File: tb/tb_vector_wb_assembler.sv
// tb_vector_wb_assembler: randomized stimulus against a queue-based model of the vector assembler.
module tb_vector_wb_assembler;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cmd_valid = 1'b0;
  logic [3:0]   cmd_dest = '0;
  logic         cmd_ready;
  logic         lane_valid = 1'b0;
  logic [7:0]   lane_data = '0;
  logic         lane_ready;
  logic         flush = 1'b0;
  logic         wre;
  logic [3:0]   a3;
  logic [127:0] wd3;
  logic         busy;
  logic [4:0]   lane_cnt;

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  vector_wb_assembler dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_dest(cmd_dest), .cmd_ready(cmd_ready),
    .lane_valid(lane_valid), .lane_data(lane_data), .lane_ready(lane_ready), .flush(flush),
    .wre(wre), .a3(a3), .wd3(wd3), .busy(busy), .lane_cnt(lane_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 collecting, 2 writing; accepted lanes kept as a byte queue.
  int           m_mode = 0;
  logic [3:0]   m_dest = '0, m_a3 = '0;
  logic [127:0] m_wd3 = '0;
  logic [7:0]   m_bytes[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_dest = '0; m_a3 = '0; m_wd3 = '0; m_bytes.delete();
    end else if (m_mode == 0) begin
      if (cmd_valid) begin m_dest = cmd_dest; m_bytes.delete(); m_mode = 1; end
    end else if (m_mode == 1) begin
      if (lane_valid) m_bytes.push_back(lane_data);
      if (flush || m_bytes.size() == 16) begin
        m_wd3 = '0;
        foreach (m_bytes[i]) m_wd3[i*8 +: 8] = m_bytes[i];
        m_a3 = m_dest;
        m_mode = 2;
      end
    end else m_mode = 0;
  end

  int wre_cnt = 0;
  logic [3:0]   cap_a3;
  logic [127:0] cap_wd3;
  logic [4:0]   cap_cnt;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wre", wre, m_mode == 2);
      chk("a3", a3, m_a3);
      chk("wd3", wd3, m_wd3);
      chk("busy", busy, m_mode != 0);
      chk("cmd_ready", cmd_ready, m_mode == 0);
      chk("lane_ready", lane_ready, m_mode == 1);
      chk("lane_cnt", lane_cnt, m_bytes.size());
    end
    if (wre === 1'b1) begin wre_cnt++; cap_a3 = a3; cap_wd3 = wd3; cap_cnt = lane_cnt; end
  end

  task automatic idle_in();
    cmd_valid = 0; lane_valid = 0; flush = 0;
  endtask

  task automatic send_cmd(input logic [3:0] d);
    int k = 0;
    cmd_valid = 1; cmd_dest = d;
    while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
    if (k == 100) begin failures++; $display("FAIL cmd_timeout got=busy exp=ready"); end
    @(negedge clk);
    cmd_valid = 0; cmd_dest = 4'($urandom);
  endtask

  task automatic send_lanes(input logic [7:0] base, input int n, input bit gaps);
    int i = 0, k = 0;
    while (i < n && k < 500) begin
      lane_valid = gaps ? 1'($urandom) : 1'b1;
      lane_data  = base + 8'(i);
      if (lane_valid && lane_ready) i++;
      @(negedge clk);
      k++;
    end
    if (k == 500) begin failures++; $display("FAIL lane_timeout got=%0d exp=%0d", i, n); end
  endtask

  int w0;

  initial begin
    #2 rst_n = 0;
    #1 chk_en = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_lane_cnt", lane_cnt, 0);

    w0 = wre_cnt;
    send_cmd(5);
    send_lanes(8'h00, 16, 0);
    idle_in();
    repeat (3) @(negedge clk);
    chk("s1_pulses", wre_cnt - w0, 1);
    chk("s1_a3", cap_a3, 5);
    chk("s1_wd3", cap_wd3, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("s1_cnt", cap_cnt, 16);

    w0 = wre_cnt;
    send_cmd(3);
    send_lanes(8'hA0, 16, 1);
    idle_in();
    repeat (3) @(negedge clk);
    chk("s2_pulses", wre_cnt - w0, 1);
    chk("s2_a3", cap_a3, 3);
    chk("s2_wd3", cap_wd3, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);

    send_cmd(9);
    send_lanes(8'h11, 1, 0);
    send_lanes(8'h22, 1, 0);
    send_lanes(8'h33, 1, 0);
    lane_valid = 1; lane_data = 8'h44; flush = 1;
    @(negedge clk);
    idle_in();
    chk("s3_wre", wre, 1);
    chk("s3_a3", a3, 9);
    chk("s3_wd3", wd3, 128'h44332211);
    chk("s3_cnt", lane_cnt, 4);
    @(negedge clk);

    send_cmd(2);
    flush = 1;
    @(negedge clk);
    flush = 0; cmd_valid = 1; cmd_dest = 7;
    chk("s4_wre", wre, 1);
    chk("s4_a3", a3, 2);
    chk("s4_wd3", wd3, 0);
    chk("s4_hold_ready", cmd_ready, 0);
    @(negedge clk);
    chk("s4_idle_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    chk("s4_busy", busy, 1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("s4b_a3", a3, 7);
    @(negedge clk);

    w0 = wre_cnt;
    send_cmd(12);
    send_lanes(8'h50, 7, 0);
    lane_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("r_wre", wre, 0);
    chk("r_a3", a3, 0);
    chk("r_wd3", wd3, 0);
    chk("r_busy", busy, 0);
    chk("r_cnt", lane_cnt, 0);
    chk("r_lane_ready", lane_ready, 0);
    chk("r_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("r_no_pulse", wre_cnt - w0, 0);
    send_cmd(6);
    send_lanes(8'hC3, 16, 1);
    idle_in();
    repeat (2) @(negedge clk);
    chk("r_after_wd3", cap_wd3, 128'hD2D1D0CFCECDCCCBCAC9C8C7C6C5C4C3);

    for (int t = 0; t < 40; t++) begin
      int n;
      lane_valid = 1'($urandom); flush = 1'($urandom); lane_data = 8'($urandom);
      @(negedge clk);
      idle_in();
      send_cmd(4'($urandom));
      n = $urandom_range(0, 16);
      send_lanes(8'($urandom), n, 1);
      if (n < 16) begin
        flush = 1; lane_valid = 1'($urandom); lane_data = 8'($urandom);
        @(negedge clk);
      end
      idle_in();
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
